// File: rtl/inst_fetch_unit_if.sv
// Fetch-side bus bundle for inst_fetch_unit: ROM port, redirect request,
// decode handshake and the sticky error flag.
interface inst_fetch_unit_if #(
  parameter int ROM_AW = 5
);
  logic [ROM_AW-1:0] rom_addr;
  logic [31:0]       rom_inst;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_pc;
  logic [31:0]       out_inst;
  logic              fetch_err;

  modport master (
    output rom_addr,
    input  rom_inst,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_pc,
    output out_inst,
    output fetch_err
  );

  modport slave (
    input  rom_addr,
    output rom_inst,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_pc,
    input  out_inst,
    input  fetch_err
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, reads the ROM and queues {pc, inst}
// pairs in a 2-entry buffer. Optional J predecode is enabled by FETCH_JPREDICT_EN.
module inst_fetch_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          ROM_AW   = 5
) (
  input  logic              clk,
  input  logic              rst,
  inst_fetch_unit_if.master bus
);

  logic [31:0] fpc_r;
  logic [31:0] mem_pc_r   [2];
  logic [31:0] mem_inst_r [2];
  logic [1:0]  count_r;
  logic        rd_ptr_r;
  logic        wr_ptr_r;
  logic        valid_r;
  logic        fetch_err_r;

  logic        pop_s;
  logic        push_s;
  logic        misaligned_s;
  logic [1:0]  count_next_s;
  logic [31:0] next_pc_s;
  logic [31:0] redirect_target_s;

`ifdef FETCH_JPREDICT_EN
  // J target keeps the top nibble of the J's own PC; JAL/JR/branches fall through.
  function automatic logic [31:0] predict_next_pc(input logic [31:0] pc,
                                                  input logic [31:0] inst);
    logic [31:0] result;
    if (inst[31:26] == 6'b000010) begin
      result = {pc[31:28], inst[25:0], 2'b00};
    end else begin
      result = pc + 32'd4;
    end
    return result;
  endfunction

  assign next_pc_s = predict_next_pc(fpc_r, bus.rom_inst);
`else
  assign next_pc_s = fpc_r + 32'd4;
`endif

  assign redirect_target_s = {bus.redirect_pc[31:2], 2'b00};
  assign misaligned_s      = (bus.redirect_pc[1:0] != 2'b00);

  // Handshake decode: a redirect suppresses the push but not a pop in the same cycle.
  always_comb begin
    pop_s        = 1'b0;
    push_s       = 1'b0;
    count_next_s = count_r;
    pop_s = valid_r & bus.out_ready;
    if (bus.redirect_valid) begin
      push_s       = 1'b0;
      count_next_s = 2'd0;
    end else begin
      push_s = (count_r != 2'd2) | pop_s;
      case ({push_s, pop_s})
        2'b10:   count_next_s = count_r + 2'd1;
        2'b01:   count_next_s = count_r - 2'd1;
        default: count_next_s = count_r;
      endcase
    end
  end

  // Fetch PC, occupancy, pointers and the sticky misalignment flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc_r       <= PC_RESET;
      count_r     <= 2'd0;
      valid_r     <= 1'b0;
      rd_ptr_r    <= 1'b0;
      wr_ptr_r    <= 1'b0;
      fetch_err_r <= 1'b0;
    end else begin
      count_r <= count_next_s;
      valid_r <= (count_next_s != 2'd0);
      if (bus.redirect_valid) begin
        fpc_r       <= redirect_target_s;
        rd_ptr_r    <= 1'b0;
        wr_ptr_r    <= 1'b0;
        fetch_err_r <= fetch_err_r | misaligned_s;
      end else begin
        if (push_s) begin
          fpc_r    <= next_pc_s;
          wr_ptr_r <= ~wr_ptr_r;
        end else begin
          fpc_r    <= fpc_r;
          wr_ptr_r <= wr_ptr_r;
        end
        if (pop_s) begin
          rd_ptr_r <= ~rd_ptr_r;
        end else begin
          rd_ptr_r <= rd_ptr_r;
        end
        fetch_err_r <= fetch_err_r;
      end
    end
  end

  // Buffer storage; cleared on reset so the head reads as zero before the first fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_pc_r[0]   <= 32'h0000_0000;
      mem_pc_r[1]   <= 32'h0000_0000;
      mem_inst_r[0] <= 32'h0000_0000;
      mem_inst_r[1] <= 32'h0000_0000;
    end else if (push_s) begin
      mem_pc_r[wr_ptr_r]   <= fpc_r;
      mem_inst_r[wr_ptr_r] <= bus.rom_inst;
    end else begin
      mem_pc_r[wr_ptr_r]   <= mem_pc_r[wr_ptr_r];
      mem_inst_r[wr_ptr_r] <= mem_inst_r[wr_ptr_r];
    end
  end

  // Addresses past the ROM depth alias onto low words by truncation.
  assign bus.rom_addr  = fpc_r[ROM_AW+1:2];
  assign bus.out_valid = valid_r;
  assign bus.out_pc    = mem_pc_r[rd_ptr_r];
  assign bus.out_inst  = mem_inst_r[rd_ptr_r];
  assign bus.fetch_err = fetch_err_r;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed self-checking bench for inst_fetch_unit with a 32-word ROM model.
module tb_inst_fetch_unit;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;
  logic [31:0] rom [32];

  inst_fetch_unit_if #(.ROM_AW(5)) bus ();

  inst_fetch_unit #(.PC_RESET(32'h0000_0000), .ROM_AW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.rom_inst = rom[bus.rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic expect_head(input string tag, input logic [31:0] pc, input logic [31:0] inst);
    check({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    check({tag, "_pc"}, bus.out_pc, pc);
    check({tag, "_inst"}, bus.out_inst, inst);
  endtask

  initial begin
    tests_run          = 0;
    tests_failed       = 0;
    for (int i = 0; i < 32; i++) rom[i] = 32'h0000_0000;
    rom[0]  = 32'h2401_0001;
    rom[1]  = 32'h0001_1100;
    rom[2]  = 32'h0041_1821;
    rom[3]  = 32'h0002_2082;
    rom[4]  = 32'h0000_0010;
    rom[5]  = 32'hAC25_0013;
    rom[7]  = 32'h00C3_3825;
    rom[8]  = 32'h0000_0020;
    rom[11] = 32'h0800_0000;
    rom[31] = 32'hDEAD_BEEF;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0000_0000;
    bus.out_ready      = 1'b1;
    rst                = 1'b1;
    #2;

    // Reset state
    check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_pc", bus.out_pc, 32'h0);
    check("rst_inst", bus.out_inst, 32'h0);
    check("rst_err", {31'd0, bus.fetch_err}, 32'd0);
    check("rst_addr", {27'd0, bus.rom_addr}, 32'd0);

    // Streaming with out_ready high
    do_reset();
    tick(); expect_head("s0", 32'h00, 32'h2401_0001);
    tick(); expect_head("s1", 32'h04, 32'h0001_1100);
    tick(); expect_head("s2", 32'h08, 32'h0041_1821);
    tick(); expect_head("s3", 32'h0C, 32'h0002_2082);

    // Backpressure: fill to two, stall, then release
    bus.out_ready = 1'b0;
    do_reset();
    tick(); expect_head("bp0", 32'h00, 32'h2401_0001);
    check("bp0_addr", {27'd0, bus.rom_addr}, 32'd1);
    tick(); tick(); tick();
    expect_head("bp3", 32'h00, 32'h2401_0001);
    check("bp3_addr", {27'd0, bus.rom_addr}, 32'd2);
    bus.out_ready = 1'b1;
    tick(); expect_head("rel0", 32'h04, 32'h0001_1100);
    tick(); expect_head("rel1", 32'h08, 32'h0041_1821);
    tick(); expect_head("rel2", 32'h0C, 32'h0002_2082);

    // Redirect to 0x14 while head is 0x08
    do_reset();
    tick(); tick(); tick();
    expect_head("pre_rd", 32'h08, 32'h0041_1821);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0014;
    tick();
    bus.redirect_valid = 1'b0;
    check("rd_bubble", {31'd0, bus.out_valid}, 32'd0);
    check("rd_addr", {27'd0, bus.rom_addr}, 32'd5);
    tick(); expect_head("rd_tgt", 32'h14, 32'hAC25_0013);
    tick(); expect_head("rd_next", 32'h18, 32'h0000_0000);

    // Misaligned redirect to 0x1E
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_001E;
    tick();
    bus.redirect_valid = 1'b0;
    check("mis_err", {31'd0, bus.fetch_err}, 32'd1);
    check("mis_bubble", {31'd0, bus.out_valid}, 32'd0);
    tick(); expect_head("mis_tgt", 32'h1C, 32'h00C3_3825);
    tick(); tick();
    check("mis_sticky", {31'd0, bus.fetch_err}, 32'd1);
    expect_head("mis_run", 32'h24, 32'h0000_0000);

    // Jump at 0x2C; reset first clears the sticky flag
    do_reset();
    check("err_clr", {31'd0, bus.fetch_err}, 32'd0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_002C;
    tick();
    bus.redirect_valid = 1'b0;
    tick(); expect_head("j_inst", 32'h2C, 32'h0800_0000);
    tick();
`ifdef FETCH_JPREDICT_EN
    expect_head("j_after", 32'h00, 32'h2401_0001);
`else
    expect_head("j_after", 32'h30, 32'h0000_0000);
`endif

    // PC wrap from FFFF_FFFC to 0
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    tick();
    bus.redirect_valid = 1'b0;
    tick(); expect_head("wrap_top", 32'hFFFF_FFFC, 32'hDEAD_BEEF);
    tick(); expect_head("wrap_zero", 32'h0000_0000, 32'h2401_0001);

    // Asynchronous reset with a full buffer
    bus.out_ready = 1'b0;
    do_reset();
    tick(); tick();
    expect_head("full", 32'h00, 32'h2401_0001);
    #2;
    rst = 1'b1;
    #1;
    check("async_valid", {31'd0, bus.out_valid}, 32'd0);
    check("async_addr", {27'd0, bus.rom_addr}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    tick(); expect_head("post_rst", 32'h00, 32'h2401_0001);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
